clock_invert_ctrl: RTL and testbench

Control-side companion to the glitch-free clock stretch/invert mux: it owns the mux `sel` line and turns single-cycle polarity requests from the UART receive path into a `sel` waveform the mux can consume safely. It guarantees a minimum dwell between `sel` transitions, reports when the inverted or normal clock has settled, and counts polarity changes for debug. It sits in the `clk` domain next to the mux, with `sel` driven straight from a flop.

---
 rtl/clock_invert_ctrl.sv | 89 ++++++++
 tb/tb_clock_invert_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/clock_invert_ctrl.sv
// Polarity-select controller for the glitch-free clock invert mux.
// Enforces a minimum dwell on sel, flags completion, counts toggles.
module clock_invert_ctrl #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic                 req_invert,
    output logic                 req_ready,
    input  logic                 cnt_clear,
    output logic                 sel,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] toggle_count
);

    // Dwell below 2 cycles would let the mux see sel edges too close together.
    localparam int HOLD_EFF = (HOLD_CYCLES < 2) ? 2 : HOLD_CYCLES;
    localparam int HW = $clog2(HOLD_EFF);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_EFF - 1);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [HW-1:0] hold_cnt;
    logic          settle_flag;
    logic          accept;
    logic          change;
    logic          same;

    assign accept = req_valid & req_ready;
    assign change = accept & (req_invert != sel);
    assign same   = accept & (req_invert == sel);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (change) state_nxt = HOLD;
            HOLD: if (hold_cnt == '0) state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        busy      = (state == HOLD);
    end

    // settle_flag delays done by one extra cycle to cover the mux pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt     <= '0;
            sel          <= 1'b0;
            settle_flag  <= 1'b0;
            done         <= 1'b0;
            toggle_count <= '0;
        end else begin
            if (change) begin
                hold_cnt <= HOLD_LOAD;
            end else if (state == HOLD && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
            if (change) begin
                sel <= req_invert;
            end
            settle_flag <= change;
            done        <= same | settle_flag;
            if (cnt_clear) begin
                toggle_count <= '0;
            end else if (change) begin
                toggle_count <= toggle_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clock_invert_ctrl.sv
// Directed bench for clock_invert_ctrl: vector table on a HOLD=4 instance,
// hand sequences for wrap/clear/min-hold and async reset mid-HOLD.
module tb_clock_invert_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Instance A: HOLD_CYCLES=4, CNT_WIDTH=8
    logic       va = 0, ia = 0, ca = 0;
    logic       ra, sa, ba, da;
    logic [7:0] cnta;

    clock_invert_ctrl #(.HOLD_CYCLES(4), .CNT_WIDTH(8)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(va), .req_invert(ia), .req_ready(ra),
        .cnt_clear(ca), .sel(sa), .busy(ba), .done(da),
        .toggle_count(cnta)
    );

    // Instance B: HOLD_CYCLES=0 (acts as 2), CNT_WIDTH=2
    logic       vb = 0, ib = 0, cb = 0;
    logic       rb, sb, bb, db;
    logic [1:0] cntb;

    clock_invert_ctrl #(.HOLD_CYCLES(0), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(vb), .req_invert(ib), .req_ready(rb),
        .cnt_clear(cb), .sel(sb), .busy(bb), .done(db),
        .toggle_count(cntb)
    );

    typedef struct {
        logic       v, inv, clr;
        logic       s, b, r, d;
        logic [7:0] c;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic inv, input logic clr,
                       input logic s, input logic b, input logic r,
                       input logic d, input logic [7:0] c);
        vec_t x;
        x.v = v; x.inv = inv; x.clr = clr;
        x.s = s; x.b = b; x.r = r; x.d = d; x.c = c;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic pol;
    int   last_acc;
    int   acc;
    logic got;

    initial begin
        // v inv clr | sel busy ready done count  (one row per cycle)
        add(0, 0, 0, 0, 0, 1, 0, 0);  // 0 idle
        add(1, 1, 0, 0, 0, 1, 0, 0);  // 1 invert accepted
        add(1, 0, 0, 1, 1, 0, 0, 1);  // 2 held normal req ignored
        add(1, 0, 0, 1, 1, 0, 1, 1);  // 3 done at N+2
        add(1, 0, 0, 1, 1, 0, 0, 1);  // 4
        add(1, 0, 0, 1, 1, 0, 0, 1);  // 5 last busy
        add(1, 0, 0, 1, 0, 1, 0, 1);  // 6 held req accepted
        add(0, 0, 0, 0, 1, 0, 0, 2);  // 7 sel edge 5 cycles after 2
        add(0, 0, 0, 0, 1, 0, 1, 2);  // 8
        add(0, 0, 0, 0, 1, 0, 0, 2);  // 9
        add(0, 0, 0, 0, 1, 0, 0, 2);  // 10
        add(1, 0, 0, 0, 0, 1, 0, 2);  // 11 same-polarity
        add(0, 0, 0, 0, 0, 1, 1, 2);  // 12 done next cycle
        add(0, 0, 1, 0, 0, 1, 0, 2);  // 13 clear
        add(1, 1, 1, 0, 0, 1, 0, 0);  // 14 clear + toggle
        add(0, 0, 0, 1, 1, 0, 0, 0);  // 15 clear wins
        add(0, 0, 0, 1, 1, 0, 1, 0);  // 16
        add(0, 0, 0, 1, 1, 0, 0, 0);  // 17
        add(0, 0, 0, 1, 1, 0, 0, 0);  // 18
        add(0, 0, 0, 1, 0, 1, 0, 0);  // 19 ready again

        repeat (3) @(negedge clk);
        chk("reset_sel", {31'd0, sa}, 32'd0);
        chk("reset_ready", {31'd0, ra}, 32'd1);
        chk("reset_busy", {31'd0, ba}, 32'd0);
        chk("reset_done", {31'd0, da}, 32'd0);
        chk("reset_count", {24'd0, cnta}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {24'd0, sa, ba, ra, da, 4'd0},
                {24'd0, vecs[i].s, vecs[i].b, vecs[i].r, vecs[i].d, 4'd0});
            chk($sformatf("vec%0d_cnt", i), {24'd0, cnta},
                {24'd0, vecs[i].c});
            va = vecs[i].v;
            ia = vecs[i].inv;
            ca = vecs[i].clr;
        end
        @(negedge clk);
        va = 0; ia = 0; ca = 0;

        // Instance B: continuous alternating requests, wrap at 2 bits
        pol = 1'b0;
        last_acc = -1;
        for (int k = 1; k <= 6; k++) begin
            pol = ~pol;
            vb = 1'b1;
            ib = pol;
            got = 1'b0;
            for (int t = 0; t < 10 && !got; t++) begin
                if (rb) got = 1'b1;
                else @(negedge clk);
            end
            if (!got) begin
                tests++; fails++;
                $display("FAIL b_ready_timeout%0d: got 0 expected 1", k);
            end
            if (k == 6) cb = 1'b1;
            acc = cyc;
            @(negedge clk);
            cb = 1'b0;
            if (last_acc >= 0)
                chk($sformatf("b_gap%0d", k), acc - last_acc, 32'd3);
            last_acc = acc;
            chk($sformatf("b_sel%0d", k), {31'd0, sb}, {31'd0, pol});
            chk($sformatf("b_busy%0d", k), {31'd0, bb}, 32'd1);
            chk($sformatf("b_cnt%0d", k), {30'd0, cntb},
                (k == 6) ? 32'd0 : 32'(k % 4));
        end
        vb = 1'b0;

        // Async reset in the middle of a HOLD with sel = 1 on instance A
        va = 1'b1; ia = 1'b0;
        @(negedge clk);
        va = 1'b0;
        repeat (5) @(negedge clk);
        chk("a_pre_ready", {31'd0, ra}, 32'd1);
        va = 1'b1; ia = 1'b1;
        @(negedge clk);
        va = 1'b0;
        @(negedge clk);
        chk("a_pre_sel", {31'd0, sa}, 32'd1);
        chk("a_pre_busy", {31'd0, ba}, 32'd1);
        chk("a_pre_cnt", {24'd0, cnta}, 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_sel", {31'd0, sa}, 32'd0);
        chk("rst_async_cnt", {24'd0, cnta}, 32'd0);
        chk("rst_async_busy", {31'd0, ba}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rel_ready", {31'd0, ra}, 32'd1);
        chk("rst_rel_sel", {31'd0, sa}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
